// File: rtl/ifu_fetch_align_pkg.sv
// Shared types and helpers for the instruction fetch/align stage.
package ifu_pkg;

  localparam int PARCEL_W = 16;

  typedef logic [PARCEL_W-1:0] parcel_t;

  // Low two bits of a parcel that mark the start of a 32-bit instruction.
  localparam logic [1:0] ILEN_32_CODE = 2'b11;

  // Number of parcels moved into or out of the parcel buffer in one cycle.
  typedef enum logic [1:0] {
    XFER_NONE = 2'd0,
    XFER_ONE  = 2'd1,
    XFER_TWO  = 2'd2
  } xfer_t;

  // A parcel starts a compressed (16-bit) instruction unless its low bits are 2'b11.
  function automatic logic is_rvc(input parcel_t p);
    return p[1:0] != ILEN_32_CODE;
  endfunction

endpackage

// File: rtl/ifu_fetch_align_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
interface ifu_fetch_align_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  // Fetch stage side: issues word requests, receives words in request order.
  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  // Memory side.
  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/ifu_fetch_align_parcel_fifo.sv
// Circular buffer of 16-bit instruction parcels. Up to two parcels pushed and
// up to two popped per cycle; the two oldest entries are visible as head0/head1.
module parcel_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  xfer_t                  push_n,
  input  parcel_t                push_p0,
  input  parcel_t                push_p1,
  input  xfer_t                  pop_n,
  output parcel_t                head0,
  output parcel_t                head1,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  parcel_t            store [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr_p1;
  logic [PTR_W-1:0]   wr_ptr_p1;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  assign rd_ptr_p1 = rd_ptr + PTR_W'(1);
  assign wr_ptr_p1 = wr_ptr + PTR_W'(1);

  assign head0 = store[rd_ptr];
  assign head1 = store[rd_ptr_p1];

  // Parcel storage write; the lower parcel of a word always lands first.
  // NOTE: the data array has no reset -- count/pointers alone say which
  // entries are live, and leaving the array unreset lets it map to plain RAM.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values,
    // independent of statement order.
    if (push_n != XFER_NONE) store[wr_ptr] <= push_p0;
    if (push_n == XFER_TWO)  store[wr_ptr_p1] <= push_p1;
  end

  // Pointer and occupancy update; flush empties the buffer in one cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(pop_n);
      wr_ptr <= wr_ptr + PTR_W'(push_n);
      count  <= count + CNT_W'(push_n) - CNT_W'(pop_n);
    end
  end

  // The request gate upstream reserves room for every word in flight, so
  // these can only fire on a design error.
  no_overflow: assert property (@(posedge clk) disable iff (rst || flush)
    (int'(count) + int'(push_n) - int'(pop_n)) <= DEPTH);

  no_underflow: assert property (@(posedge clk) disable iff (rst || flush)
    int'(pop_n) <= int'(count));

endmodule

// File: rtl/ifu_fetch_align.sv
// Fetch/align stage: owns the fetch PC, issues word-aligned imem requests,
// buffers returned parcels and presents one aligned RV32IC instruction per
// cycle to decode, together with its PC.
module ifu_fetch_align
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BUF_PARCELS = 4,
  parameter int          MAX_OUTST   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               next_pc,
  input  logic                      redirect,
  ifu_fetch_align_if.master         imem,
  input  logic                      id_ready,
  output logic                      ins_valid_l0,
  output logic [31:0]               ins_l0,
  output logic [1:0]                ins_2bit_l0,
  output logic [31:0]               pc_l0
);

  localparam int CNT_W  = $clog2(BUF_PARCELS) + 1;
  localparam int OST_W  = $clog2(MAX_OUTST + 1);
  localparam int GATE_W = CNT_W + OST_W + 2;

  parcel_t            head0;
  parcel_t            head1;
  logic [CNT_W-1:0]   count;
  xfer_t              push_n;
  parcel_t            push_p0;
  parcel_t            push_p1;
  xfer_t              pop_n;

  logic [31:0]        fetch_addr;
  logic               drop_low;
  logic [OST_W-1:0]   outstanding;
  logic [OST_W-1:0]   outstanding_nxt;
  logic [OST_W-1:0]   drop_cnt;

  logic               head_is_32;
  logic               complete;
  logic               consume;
  logic [GATE_W-1:0]  committed;
  logic               req_fire;
  logic               rsp_drop;
  logic               rsp_keep;

  parcel_fifo #(.DEPTH(BUF_PARCELS)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect),
    .push_n  (push_n),
    .push_p0 (push_p0),
    .push_p1 (push_p1),
    .pop_n   (pop_n),
    .head0   (head0),
    .head1   (head1),
    .count   (count)
  );

  // Align: a 32-bit instruction needs both head parcels present.
  assign head_is_32   = !is_rvc(head0);
  assign complete     = head_is_32 ? (count >= CNT_W'(2)) : (count != '0);
  assign ins_valid_l0 = complete && !redirect;
  assign ins_l0       = head_is_32 ? {head1, head0} : {16'h0000, head0};
  assign ins_2bit_l0  = (count == '0) ? 2'b00 : head0[1:0];
  assign consume      = ins_valid_l0 && id_ready;

  // Parcels already buffered plus two per word still owed by memory (words
  // that will be dropped excluded), plus the word about to be requested.
  assign committed = GATE_W'(count)
                   + (GATE_W'(outstanding - drop_cnt) << 1)
                   + GATE_W'(2);

  assign imem.imem_req_valid = !rst && !redirect
                            && (committed <= GATE_W'(BUF_PARCELS))
                            && (outstanding < OST_W'(MAX_OUTST));
  assign imem.imem_req_addr  = fetch_addr;

  assign req_fire = imem.imem_req_valid && imem.imem_req_ready;
  assign rsp_drop = imem.imem_rsp_valid && (drop_cnt != '0);
  assign rsp_keep = imem.imem_rsp_valid && (drop_cnt == '0);

  // Words in flight after this edge, counting this cycle's request and response.
  assign outstanding_nxt = outstanding + OST_W'(req_fire) - OST_W'(imem.imem_rsp_valid);

  // Pop the head instruction's parcels when decode takes it.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    pop_n = XFER_NONE;
    if (consume) pop_n = head_is_32 ? XFER_TWO : XFER_ONE;
  end

  // Push a returned word; after a jump to a half-word target only the upper parcel is kept.
  always_comb begin
    push_n  = XFER_NONE;
    push_p0 = imem.imem_rsp_data[15:0];
    push_p1 = imem.imem_rsp_data[31:16];
    if (rsp_keep && !redirect) begin
      if (drop_low) begin
        push_n  = XFER_ONE;
        push_p0 = imem.imem_rsp_data[31:16];
      end else begin
        push_n  = XFER_TWO;
      end
    end
  end

  // PC, fetch address and in-flight bookkeeping; redirect overrides everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_l0       <= RESET_PC;
      fetch_addr  <= RESET_PC & ~32'h3;
      drop_low    <= RESET_PC[1];
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect) begin
        pc_l0      <= next_pc;
        fetch_addr <= next_pc & ~32'h3;
        drop_low   <= next_pc[1];
        drop_cnt   <= outstanding_nxt;
      end else begin
        if (consume)             pc_l0      <= next_pc;
        if (req_fire)            fetch_addr <= fetch_addr + 32'd4;
        if (rsp_drop)            drop_cnt   <= drop_cnt - OST_W'(1);
        if (rsp_keep && drop_low) drop_low  <= 1'b0;
      end
    end
  end

endmodule
